// File: rtl/if_stage_param.sv
// if_stage_param
// Instruction-fetch stage with a writable instruction memory and an integrated
// IF/ID pipeline register.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset (memory contents survive it)
//   freeze         hazard stall: hold PC and IF/ID
//   branch_taken   redirect fetch to branch_address (beats freeze)
//   branch_address target byte address, low two bits dropped (flagged if set)
//   imem_we        program-load write enable
//   imem_waddr     program-load word index
//   imem_wdata     program-load data word
//   pc             current fetch PC (byte address)
//   ifid_instr     registered instruction handed to ID
//   ifid_pc        registered PC+4 of that instruction
//   ifid_valid     IF/ID holds a real instruction
//   fetch_fault    sticky flag: out-of-range fetch or misaligned branch seen
module if_stage_param #(
  parameter int                DATA_W     = 32,
  parameter int                IMEM_DEPTH = 128,
  parameter int                IDX_W      = 7,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] NOP_WORD   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_address,
  input  logic              imem_we,
  input  logic [IDX_W-1:0]  imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [DATA_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              fetch_fault
);

  // Instruction storage. The read is asynchronous because the word must be
  // available in the same cycle the PC presents its index.
  logic [DATA_W-1:0] mem [IMEM_DEPTH];

  // One "has been written" bit per word so that never-loaded words read as
  // NOP_WORD instead of undefined data. These bits take their cleared value
  // only at power-up; rst deliberately leaves them (and mem) alone so a
  // program loaded during reset survives it.
  logic [IMEM_DEPTH-1:0] word_valid = '0;

  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] ifid_pc_reg;
  logic              valid_reg;
  logic              fault_reg;

  logic [IDX_W-1:0]  fetch_idx;
  logic              upper_zero;
  logic              idx_ok;
  logic              waddr_ok;
  logic              fetch_ok;
  logic [DATA_W-1:0] fetch_word;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] branch_target;
  logic              branch_misaligned;

  assign fetch_idx  = pc_reg[IDX_W+1:2];
  // Any PC bit above the memory's byte range means the fetch is off the end.
  assign upper_zero = (pc_reg[DATA_W-1:IDX_W+2] == '0);

  // When the memory fills the whole index space every index is legal and the
  // bound comparison would be constant, so it is only built for partial fills.
  generate
    if (IMEM_DEPTH == (1 << IDX_W)) begin : g_full_depth
      assign idx_ok   = 1'b1;
      assign waddr_ok = 1'b1;
    end else begin : g_partial_depth
      assign idx_ok   = (fetch_idx  < IDX_W'(IMEM_DEPTH));
      assign waddr_ok = (imem_waddr < IDX_W'(IMEM_DEPTH));
    end
  endgenerate

  assign fetch_ok          = upper_zero && idx_ok;
  assign pc_plus4          = pc_reg + DATA_W'(4);
  assign branch_target     = {branch_address[DATA_W-1:2], 2'b00};
  assign branch_misaligned = (branch_address[1:0] != 2'b00);

  always_comb begin
    fetch_word = NOP_WORD;
    if (fetch_ok && word_valid[fetch_idx]) begin
      fetch_word = mem[fetch_idx];
    end
  end

  // Program load. The fetch above reads the pre-edge contents, so a write to
  // the word being fetched on the same edge hands ID the old word.
  always_ff @(posedge clk) begin
    if (imem_we && waddr_ok) begin
      mem[imem_waddr]        <= imem_wdata;
      word_valid[imem_waddr] <= 1'b1;
    end
  end

  // PC and IF/ID register. Priority: rst, branch, freeze, advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP_WORD;
      ifid_pc_reg <= '0;
      valid_reg   <= 1'b0;
      fault_reg   <= 1'b0;
    end else if (branch_taken) begin
      // Flush the wrong-path instruction; ifid_pc is left as is since the
      // bubble it accompanies is marked invalid anyway.
      pc_reg    <= branch_target;
      instr_reg <= NOP_WORD;
      valid_reg <= 1'b0;
      if (branch_misaligned) begin
        fault_reg <= 1'b1;
      end
    end else if (!freeze) begin
      pc_reg      <= pc_plus4;
      ifid_pc_reg <= pc_plus4;
      if (fetch_ok) begin
        instr_reg <= fetch_word;
        valid_reg <= 1'b1;
      end else begin
        // Out-of-range fetch: bubble and flag, but keep running.
        instr_reg <= NOP_WORD;
        valid_reg <= 1'b0;
        fault_reg <= 1'b1;
      end
    end
  end

  assign pc          = pc_reg;
  assign ifid_instr  = instr_reg;
  assign ifid_pc     = ifid_pc_reg;
  assign ifid_valid  = valid_reg;
  assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_if_stage_param.sv
// tb_if_stage_param
// Self-checking bench for if_stage_param. A behavioural reference model is
// advanced on every driven cycle and its predicted outputs are pushed into a
// scoreboard queue; each test pops the prediction after the edge and compares
// it with the DUT, plus a few hand-derived constant checks.
module tb_if_stage_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic        imem_we;
  logic [6:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        fetch_fault;

  if_stage_param dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .pc             (pc),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        valid;
    logic        fault;
  } obs_t;

  // Reference model state
  logic [31:0] m_mem [128];
  bit          m_wv  [128];
  obs_t        m;
  obs_t        sb [$];

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] prog [4];

  function automatic obs_t obs();
    obs_t o;
    o.pc    = pc;
    o.instr = ifid_instr;
    o.ipc   = ifid_pc;
    o.valid = ifid_valid;
    o.fault = fetch_fault;
    return o;
  endfunction

  // Drive one cycle of stimulus, predict the post-edge outputs, queue the
  // prediction and advance to just after the edge.
  task automatic drive(input bit r, input bit fz, input bit br, input logic [31:0] ba,
                       input bit we, input logic [6:0] wa, input logic [31:0] wd);
    obs_t        n;
    logic [6:0]  idx;
    rst = r; freeze = fz; branch_taken = br; branch_address = ba;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    n   = m;
    idx = m.pc[8:2];
    if (r) begin
      n = '0;
    end else if (br) begin
      n.pc    = {ba[31:2], 2'b00};
      n.instr = 32'h0;
      n.valid = 1'b0;
      if (ba[1:0] != 2'b00) n.fault = 1'b1;
    end else if (!fz) begin
      n.pc  = m.pc + 32'd4;
      n.ipc = m.pc + 32'd4;
      if (m.pc[31:9] == 23'h0) begin
        n.instr = m_wv[idx] ? m_mem[idx] : 32'h0;
        n.valid = 1'b1;
      end else begin
        n.instr = 32'h0;
        n.valid = 1'b0;
        n.fault = 1'b1;
      end
    end
    if (we) begin
      m_mem[wa] = wd;
      m_wv[wa]  = 1'b1;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t exp, act;
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 32'h0, 1, 7'(k), prog[k]);
      exp = sb.pop_front(); act = obs(); n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL reset_load[%0d]: got %h want %h", k, act, exp); end
    end
    n_run++;
    if ({pc, ifid_instr, ifid_pc, ifid_valid, fetch_fault} !== 98'h0) begin
      n_fail++;
      $display("FAIL reset_vals: got pc=%h instr=%h ipc=%h v=%b f=%b want all zero",
               pc, ifid_instr, ifid_pc, ifid_valid, fetch_fault);
    end
  endtask

  task automatic test_sequence();
    obs_t exp, act;
    for (int k = 1; k <= 2; k++) begin
      drive(0, 0, 0, 32'h0, 0, 7'h0, 32'h0);
      exp = sb.pop_front(); act = obs(); n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL seq[%0d]: got %h want %h", k, act, exp); end
      n_run++;
      if (ifid_instr !== prog[k-1] || ifid_pc !== 32'(4 * k) || ifid_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_const[%0d]: got instr=%h ipc=%h v=%b want instr=%h ipc=%h v=1",
                 k, ifid_instr, ifid_pc, ifid_valid, prog[k-1], 32'(4 * k));
      end
    end
  endtask

  task automatic test_freeze();
    obs_t exp, act;
    for (int k = 0; k < 3; k++) begin
      // Load mem[6] mid-freeze: loading must be allowed while stalled.
      drive(0, 1, 0, 32'h0, k == 1, 7'd6, 32'hA5A5A5A5);
      exp = sb.pop_front(); act = obs(); n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL freeze[%0d]: got %h want %h", k, act, exp); end
      n_run++;
      if (pc !== 32'h8 || ifid_pc !== 32'h8 || ifid_instr !== prog[1] || ifid_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: got pc=%h ipc=%h instr=%h v=%b want pc=8 ipc=8 instr=%h v=1",
                 k, pc, ifid_pc, ifid_instr, ifid_valid, prog[1]);
      end
    end
    for (int k = 2; k <= 3; k++) begin
      drive(0, 0, 0, 32'h0, 0, 7'h0, 32'h0);
      exp = sb.pop_front(); act = obs(); n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL resume[%0d]: got %h want %h", k, act, exp); end
      n_run++;
      if (pc !== 32'(4 * k + 4) || ifid_instr !== prog[k]) begin
        n_fail++;
        $display("FAIL resume_const[%0d]: got pc=%h instr=%h want pc=%h instr=%h",
                 k, pc, ifid_instr, 32'(4 * k + 4), prog[k]);
      end
    end
  endtask

  task automatic test_branch_freeze();
    obs_t exp, act;
    // Branch with freeze the same cycle; also load mem[8] on that edge.
    drive(0, 1, 1, 32'h20, 1, 7'd8, 32'h00000888);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp) begin n_fail++; $display("FAIL br_freeze: got %h want %h", act, exp); end
    n_run++;
    if (pc !== 32'h20 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL br_flush: got pc=%h v=%b instr=%h want pc=20 v=0 instr=0", pc, ifid_valid, ifid_instr);
    end
    drive(0, 0, 0, 32'h0, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp) begin n_fail++; $display("FAIL br_target: got %h want %h", act, exp); end
    n_run++;
    if (ifid_instr !== 32'h00000888 || ifid_pc !== 32'h24 || ifid_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL br_target_const: got instr=%h ipc=%h v=%b want 888 24 1", ifid_instr, ifid_pc, ifid_valid);
    end
    // mem[9] was never written: it must read as a valid NOP.
    drive(0, 0, 0, 32'h0, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp || ifid_instr !== 32'h0 || ifid_valid !== 1'b1) begin
      n_fail++; $display("FAIL unwritten: got %h want %h", act, exp);
    end
  endtask

  task automatic test_misaligned();
    obs_t exp, act;
    drive(0, 0, 1, 32'h22, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp || pc !== 32'h20 || fetch_fault !== 1'b1) begin
      n_fail++; $display("FAIL misaligned: got %h want %h", act, exp);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, k == 1, 0, 32'h0, 0, 7'h0, 32'h0);
      exp = sb.pop_front(); act = obs(); n_run++;
      if (act !== exp || fetch_fault !== 1'b1) begin
        n_fail++; $display("FAIL fault_sticky[%0d]: got %h want %h", k, act, exp);
      end
    end
    drive(1, 0, 0, 32'h0, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp || fetch_fault !== 1'b0 || pc !== 32'h0) begin
      n_fail++; $display("FAIL fault_clear: got %h want %h", act, exp);
    end
  endtask

  task automatic test_range_end();
    obs_t exp, act;
    logic [31:0] ba [7];
    bit          br [7];
    logic [31:0] ba_init [7] = '{32'h0, 32'h1FC, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 32'h0};
    bit          br_init [7] = '{0, 1, 0, 0, 1, 0, 0};
    ba = ba_init;
    br = br_init;
    // Step 0 loads mem[127]; then 0x1FC, last word, then off the end;
    // then the 0xFFFFFFFC wrap back into range at 0.
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, br[k], ba[k], k == 0, 7'd127, 32'h12345678);
      exp = sb.pop_front(); act = obs(); n_run++;
      if (act !== exp) begin n_fail++; $display("FAIL range[%0d]: got %h want %h", k, act, exp); end
      if (k == 2) begin
        n_run++;
        if (ifid_instr !== 32'h12345678 || ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || fetch_fault !== 1'b0) begin
          n_fail++; $display("FAIL last_word: got instr=%h v=%b ipc=%h f=%b", ifid_instr, ifid_valid, ifid_pc, fetch_fault);
        end
      end
      if (k == 3) begin
        n_run++;
        if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0 || fetch_fault !== 1'b1 || pc !== 32'h204) begin
          n_fail++; $display("FAIL past_end: got instr=%h v=%b f=%b pc=%h", ifid_instr, ifid_valid, fetch_fault, pc);
        end
      end
      if (k == 5) begin
        n_run++;
        if (ifid_pc !== 32'h0 || pc !== 32'h0 || ifid_valid !== 1'b0) begin
          n_fail++; $display("FAIL pc_wrap: got ipc=%h pc=%h v=%b want 0 0 0", ifid_pc, pc, ifid_valid);
        end
      end
    end
  endtask

  task automatic test_write_collision();
    obs_t exp, act;
    // rst together with freeze and branch: reset must win.
    drive(1, 1, 1, 32'h40, 1, 7'd5, 32'h11111111);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp || pc !== 32'h0 || fetch_fault !== 1'b0) begin
      n_fail++; $display("FAIL rst_priority: got %h want %h", act, exp);
    end
    drive(0, 0, 1, 32'h14, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp) begin n_fail++; $display("FAIL wc_branch1: got %h want %h", act, exp); end
    drive(0, 0, 0, 32'h0, 1, 7'd5, 32'hDEADBEEF);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp || ifid_instr !== 32'h11111111) begin
      n_fail++; $display("FAIL wc_old_word: got %h want %h", act, exp);
    end
    drive(0, 0, 1, 32'h14, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp) begin n_fail++; $display("FAIL wc_branch2: got %h want %h", act, exp); end
    drive(0, 0, 0, 32'h0, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp || ifid_instr !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wc_new_word: got %h want %h", act, exp);
    end
    // mem[6] was loaded during the freeze test.
    drive(0, 0, 0, 32'h0, 0, 7'h0, 32'h0);
    exp = sb.pop_front(); act = obs(); n_run++;
    if (act !== exp || ifid_instr !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL freeze_load: got %h want %h", act, exp);
    end
  endtask

  initial begin
    prog[0] = 32'h80010001;
    prog[1] = 32'h04000800;
    prog[2] = 32'h0C000800;
    prog[3] = 32'h18000800;
    for (int i = 0; i < 128; i++) begin
      m_mem[i] = 32'h0;
      m_wv[i]  = 1'b0;
    end
    m = '0;
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
    imem_we = 1'b0; imem_waddr = 7'h0; imem_wdata = 32'h0;

    test_reset();
    test_sequence();
    test_freeze();
    test_branch_freeze();
    test_misaligned();
    test_range_end();
    test_write_collision();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
